traffic_monitor: RTL and testbench

Independent checker on the receiving end of the traffic-controller lamp interface (green/yellow/red). It samples the three lamp lines every clock and verifies one-hot encoding, the G->Y->R->G order, and the exact dwell time of each phase against the same timing parameters as the controller. Any violation latches a sticky fault with a code so that supervisory logic can force a safe state. It sits beside the controller and observes the lamp bus read-only.

---
 rtl/traffic_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_traffic_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_monitor.sv
// Read-only checker for the traffic-controller lamp bus: one-hot lamps, G->Y->R order
// and exact per-phase dwell, with a sticky coded fault for supervisory logic.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_SYNC  | waiting for the first legal lamp change; no dwell checking
// S_CHK_G | green phase under dwell check
// S_CHK_Y | yellow phase under dwell check
// S_CHK_R | red phase under dwell check
// S_FAULT | violation latched; checks suspended until clr_fault or reset
module traffic_monitor #(
  parameter int GREEN_TIME  = 10,
  parameter int YELLOW_TIME = 3,
  parameter int RED_TIME    = 7,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       green,
  input  logic       yellow,
  input  logic       red,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       phase_ok,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_CHK_G,
    S_CHK_Y,
    S_CHK_R,
    S_FAULT
  } state_t;

  localparam logic [2:0] LAMP_NONE = 3'b000;
  localparam logic [2:0] LAMP_G    = 3'b100;
  localparam logic [2:0] LAMP_Y    = 3'b010;
  localparam logic [2:0] LAMP_R    = 3'b001;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_COMBO = 3'd1;
  localparam logic [2:0] CODE_SEQ   = 3'd2;
  localparam logic [2:0] CODE_SHORT = 3'd3;
  localparam logic [2:0] CODE_LONG  = 3'd4;

  localparam logic [CNT_W-1:0] G_LIM   = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] Y_LIM   = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] R_LIM   = CNT_W'(RED_TIME);
  localparam logic [CNT_W-1:0] DWELL_1 = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [2:0]       prev_q, prev_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             phase_ok_q, phase_ok_d;
  logic [7:0]       cycle_cnt_q, cycle_cnt_d;

  logic [2:0]       lamp_s;
  logic             lamp_legal;
  logic [2:0]       cur_lamp;
  logic [CNT_W-1:0] cur_lim;
  logic [2:0]       viol;

  function automatic logic is_lamp(input logic [2:0] l);
    return (l == LAMP_G) || (l == LAMP_Y) || (l == LAMP_R);
  endfunction

  function automatic logic [2:0] succ_of(input logic [2:0] l);
    case (l)
      LAMP_G:  return LAMP_Y;
      LAMP_Y:  return LAMP_R;
      LAMP_R:  return LAMP_G;
      default: return LAMP_NONE;
    endcase
  endfunction

  function automatic state_t chk_of(input logic [2:0] l);
    case (l)
      LAMP_G:  return S_CHK_G;
      LAMP_Y:  return S_CHK_Y;
      LAMP_R:  return S_CHK_R;
      default: return S_SYNC;
    endcase
  endfunction

  always_comb begin
    lamp_s     = {green, yellow, red};
    lamp_legal = is_lamp(lamp_s);
    case (state_q)
      S_CHK_G: begin
        cur_lamp = LAMP_G;
        cur_lim  = G_LIM;
      end
      S_CHK_Y: begin
        cur_lamp = LAMP_Y;
        cur_lim  = Y_LIM;
      end
      S_CHK_R: begin
        cur_lamp = LAMP_R;
        cur_lim  = R_LIM;
      end
      default: begin
        cur_lamp = LAMP_NONE;
        cur_lim  = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    prev_d      = lamp_s;
    fault_d     = fault_q;
    code_d      = code_q;
    phase_ok_d  = 1'b0;
    cycle_cnt_d = cycle_cnt_q;
    viol        = CODE_NONE;

    if (clr_fault) begin
      // Clear wins over anything seen on this sample; counter history is kept.
      state_d = S_SYNC;
      dwell_d = '0;
      fault_d = 1'b0;
      code_d  = CODE_NONE;
    end else begin
      case (state_q)
        S_FAULT: prev_d = prev_q;
        S_SYNC: begin
          if (!lamp_legal) begin
            viol = CODE_COMBO;
          end else if (is_lamp(prev_q) && (lamp_s != prev_q)) begin
            if (lamp_s != succ_of(prev_q)) begin
              viol = CODE_SEQ;
            end else begin
              state_d = chk_of(lamp_s);
              dwell_d = DWELL_1;
            end
          end
        end
        S_CHK_G, S_CHK_Y, S_CHK_R: begin
          if (!lamp_legal) begin
            viol = CODE_COMBO;
          end else if (lamp_s == cur_lamp) begin
            // Dwell saturates at the limit; one more sample is an overrun.
            if (dwell_q == cur_lim) viol = CODE_LONG;
            else                    dwell_d = dwell_q + DWELL_1;
          end else if (lamp_s != succ_of(cur_lamp)) begin
            viol = CODE_SEQ;
          end else if (dwell_q < cur_lim) begin
            viol = CODE_SHORT;
          end else begin
            phase_ok_d = 1'b1;
            state_d    = chk_of(lamp_s);
            dwell_d    = DWELL_1;
            if (cur_lamp == LAMP_R) cycle_cnt_d = cycle_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_SYNC;
          dwell_d = '0;
        end
      endcase

      if (viol != CODE_NONE) begin
        state_d = S_FAULT;
        dwell_d = '0;
        fault_d = 1'b1;
        code_d  = viol;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SYNC;
      dwell_q     <= '0;
      prev_q      <= LAMP_NONE;
      fault_q     <= 1'b0;
      code_q      <= CODE_NONE;
      phase_ok_q  <= 1'b0;
      cycle_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      prev_q      <= prev_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      phase_ok_q  <= phase_ok_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign phase_ok   = phase_ok_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Bench for traffic_monitor: directed scenarios plus random lamp traffic, all
// compared against a run-length reference model of the lamp rules.
module tb_traffic_monitor;

  localparam int GT = 10;
  localparam int YT = 3;
  localparam int RT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       green = 1'b0;
  logic       yellow = 1'b0;
  logic       red = 1'b0;
  logic       clr_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       phase_ok;
  logic [7:0] cycle_cnt;
  logic [12:0] obs;

  int checks = 0;
  int failures = 0;

  traffic_monitor #(
    .GREEN_TIME (GT),
    .YELLOW_TIME(YT),
    .RED_TIME   (RT),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .clr_fault (clr_fault),
    .fault     (fault),
    .fault_code(fault_code),
    .phase_ok  (phase_ok),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {fault, fault_code, phase_ok, cycle_cnt};

  // Reference model: lamp index 0=G 1=Y 2=R, -1 = no usable lamp yet.
  int dwell_req[3] = '{GT, YT, RT};
  bit m_fault;
  int m_code;
  bit m_ok;
  int m_cnt;
  bit m_aligned;
  int m_lamp;
  int m_run;

  function automatic void model_reset();
    m_fault = 0; m_code = 0; m_ok = 0; m_cnt = 0;
    m_aligned = 0; m_lamp = -1; m_run = 0;
  endfunction

  function automatic void model_step(input logic g, input logic y, input logic r, input logic c);
    int n;
    int idx;
    n = int'(g) + int'(y) + int'(r);
    idx = g ? 0 : (y ? 1 : 2);
    m_ok = 0;
    if (c) begin
      m_fault = 0; m_code = 0; m_aligned = 0; m_run = 0;
      m_lamp = (n == 1) ? idx : -1;
      return;
    end
    if (m_fault) return;
    if (n != 1) begin m_fault = 1; m_code = 1; return; end
    if (!m_aligned) begin
      if (m_lamp >= 0 && idx != m_lamp) begin
        if (idx != (m_lamp + 1) % 3) begin m_fault = 1; m_code = 2; end
        else begin m_aligned = 1; m_lamp = idx; m_run = 1; end
      end else begin
        m_lamp = idx;
      end
      return;
    end
    if (idx == m_lamp) begin
      m_run++;
      if (m_run > dwell_req[idx]) begin m_fault = 1; m_code = 4; end
    end else if (idx != (m_lamp + 1) % 3) begin
      m_fault = 1; m_code = 2;
    end else if (m_run < dwell_req[m_lamp]) begin
      m_fault = 1; m_code = 3;
    end else begin
      m_ok = 1;
      if (m_lamp == 2) m_cnt = (m_cnt + 1) % 256;
      m_lamp = idx;
      m_run = 1;
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_fault, 3'(m_code), m_ok, 8'(m_cnt)};
  endfunction

  task automatic step_raw(input logic g, input logic y, input logic r, input logic c);
    @(negedge clk);
    green = g; yellow = y; red = r; clr_fault = c;
    @(posedge clk);
    if (rst) model_step(g, y, r, c);
    #1;
  endtask

  task automatic drive(input int l, input logic c);
    step_raw(l == 0, l == 1, l == 2, c);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) drive(0, 1'b0);
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    checks++; if (fault_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", fault_code); end
    checks++; if (phase_ok !== 1'b0) begin failures++; $display("FAIL reset_phase_ok got=%0b exp=0", phase_ok); end
    checks++; if (cycle_cnt !== 8'd0) begin failures++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_nominal();
    int q[$];
    int pulses = 0;
    for (int k = 0; k < 5; k++)
      for (int p = 0; p < 3; p++)
        for (int i = 0; i < dwell_req[p]; i++) q.push_back(p);
    q.push_back(0);
    foreach (q[i]) begin
      drive(q[i], 1'b0);
      pulses += int'(phase_ok);
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL nominal_s%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL nominal_fault got=%0b exp=0", fault); end
    checks++; if (cycle_cnt !== 8'd5) begin failures++; $display("FAIL nominal_cycle_cnt got=%0d exp=5", cycle_cnt); end
    checks++; if (pulses != 14) begin failures++; $display("FAIL nominal_pulses got=%0d exp=14", pulses); end
  endtask

  task automatic test_combo();
    repeat (4) drive(0, 1'b0);
    step_raw(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (obs !== exp_vec()) begin failures++; $display("FAIL combo_model got=%h exp=%h", obs, exp_vec()); end
    checks++; if ({fault, fault_code} !== {1'b1, 3'd1}) begin failures++; $display("FAIL combo_code got=%0b/%0d exp=1/1", fault, fault_code); end
    repeat (3) drive(0, 1'b0);
    checks++; if ({fault, fault_code} !== {1'b1, 3'd1}) begin failures++; $display("FAIL combo_sticky got=%0b/%0d exp=1/1", fault, fault_code); end
  endtask

  task automatic test_seq();
    drive(0, 1'b1);
    checks++; if ({fault, fault_code} !== 4'b0000) begin failures++; $display("FAIL seq_clear got=%0b/%0d exp=0/0", fault, fault_code); end
    repeat (2) drive(0, 1'b0);
    repeat (YT) drive(1, 1'b0);
    repeat (RT) drive(2, 1'b0);
    repeat (GT) drive(0, 1'b0);
    checks++; if (obs !== exp_vec()) begin failures++; $display("FAIL seq_pre got=%h exp=%h", obs, exp_vec()); end
    drive(2, 1'b0);
    checks++; if ({fault, fault_code, phase_ok} !== {1'b1, 3'd2, 1'b0}) begin failures++; $display("FAIL seq_code got=%0b/%0d/%0b exp=1/2/0", fault, fault_code, phase_ok); end
  endtask

  task automatic test_short();
    drive(2, 1'b1);
    repeat (GT) drive(0, 1'b0);
    repeat (2) drive(1, 1'b0);
    drive(2, 1'b0);
    checks++; if ({fault, fault_code} !== {1'b1, 3'd3}) begin failures++; $display("FAIL short_code got=%0b/%0d exp=1/3", fault, fault_code); end
    checks++; if (obs !== exp_vec()) begin failures++; $display("FAIL short_model got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_long();
    drive(1, 1'b1);
    repeat (RT) drive(2, 1'b0);
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL long_early got=%0b exp=0", fault); end
    drive(2, 1'b0);
    checks++; if ({fault, fault_code} !== {1'b1, 3'd4}) begin failures++; $display("FAIL long_code got=%0b/%0d exp=1/4", fault, fault_code); end
  endtask

  task automatic test_priority_clear();
    int q[$];
    int pulses = 0;
    logic [7:0] saved;
    drive(2, 1'b1);
    repeat (GT) drive(0, 1'b0);
    step_raw(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if ({fault, fault_code} !== {1'b1, 3'd1}) begin failures++; $display("FAIL prio_code got=%0b/%0d exp=1/1", fault, fault_code); end
    saved = cycle_cnt;
    drive(0, 1'b1);
    checks++; if ({fault, fault_code, cycle_cnt} !== {1'b0, 3'd0, saved}) begin failures++; $display("FAIL clear_state got=%0b/%0d/%0d exp=0/0/%0d", fault, fault_code, cycle_cnt, saved); end
    for (int i = 0; i < GT - 1; i++) q.push_back(0);
    for (int i = 0; i < YT; i++) q.push_back(1);
    for (int i = 0; i < RT; i++) q.push_back(2);
    q.push_back(0);
    foreach (q[i]) begin
      drive(q[i], 1'b0);
      pulses += int'(phase_ok);
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL resume_s%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    checks++; if (pulses != 2 || fault !== 1'b0) begin failures++; $display("FAIL resume_pulses got=%0d/%0b exp=2/0", pulses, fault); end
  endtask

  task automatic test_async_reset();
    int q[$];
    int pulses = 0;
    repeat (GT - 1) drive(0, 1'b0);
    repeat (2) drive(1, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (obs !== 13'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", obs); end
    drive(1, 1'b0);
    repeat (3) drive(2, 1'b0);
    checks++; if (obs !== 13'd0) begin failures++; $display("FAIL reset_hold got=%h exp=0", obs); end
    rst = 1'b1;
    for (int i = 0; i < RT - 3; i++) q.push_back(2);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < dwell_req[p]; i++) q.push_back(p);
    q.push_back(0);
    foreach (q[i]) begin
      drive(q[i], 1'b0);
      pulses += int'(phase_ok);
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL realign_s%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    checks++; if ({fault, cycle_cnt} !== {1'b0, 8'd1} || pulses != 3) begin failures++; $display("FAIL realign_end got=%0b/%0d/%0d exp=0/1/3", fault, cycle_cnt, pulses); end
  endtask

  task automatic test_random();
    int l = 2;
    int rem = 0;
    logic [2:0] v;
    logic c;
    drive(2, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      if (rem == 0) begin
        if ($urandom_range(0, 19) == 0) l = $urandom_range(0, 2);
        else l = (l + 1) % 3;
        rem = dwell_req[l];
        if ($urandom_range(0, 5) == 0) rem = rem + (($urandom_range(0, 1) == 1) ? 1 : -1);
      end
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) v = 3'($urandom_range(0, 7));
      else v = (l == 0) ? 3'b100 : ((l == 1) ? 3'b010 : 3'b001);
      step_raw(v[2], v[1], v[0], c);
      rem--;
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL random_n%0d got=%h exp=%h", n, obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_combo();
    test_seq();
    test_short();
    test_long();
    test_priority_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
